// File: rtl/serial_addsub6_pkg.sv
// Shared types and constants for the bit-serial add/subtract/compare unit.
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 6;
    localparam int CNT_WIDTH     = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/serial_addsub6_if.sv
// Operand/result handshake bundle for serial_addsub6.
// The ovf signal exists only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub6_if #(
    parameter int WIDTH = serial_addsub_pkg::DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cmp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             equal;
    logic             not_equal;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, sub, cmp, out_ready,
        input  in_ready, out_valid, result, cout, equal, not_equal
`ifdef SERIAL_ADDSUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, sub, cmp, out_ready,
        output in_ready, out_valid, result, cout, equal, not_equal
`ifdef SERIAL_ADDSUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_addsub6_fa_slice.sv
// Single combinational full-adder cell, reused once per serial bit.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub6.sv
// Bit-serial add/subtract/compare, LSB first, one bit per clock.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub6
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_addsub6_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic             eq_acc;
    logic             sub_q;
    logic             cmp_q;

    logic             fa_sum;
    logic             fa_cout;
    logic             eq_next;
    logic [WIDTH-1:0] sum_next;

    fa_slice u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0] ^ sub_q),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Equality uses the un-inverted operand B, independent of sub.
    assign eq_next  = eq_acc & (a_sr[0] == b_sr[0]);
    assign sum_next = {fa_sum, sum_sr[WIDTH-1:1]};

    assign bus.in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            a_sr          <= '0;
            b_sr          <= '0;
            sum_sr        <= '0;
            carry         <= 1'b0;
            eq_acc        <= 1'b1;
            sub_q         <= 1'b0;
            cmp_q         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.cout      <= 1'b0;
            bus.equal     <= 1'b0;
            bus.not_equal <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            bus.ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        sub_q  <= bus.sub;
                        cmp_q  <= bus.cmp;
                        carry  <= bus.sub;
                        cnt    <= '0;
                        eq_acc <= 1'b1;
                        sum_sr <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    carry  <= fa_cout;
                    eq_acc <= eq_next;
                    cnt    <= cnt + 1'b1;
                    // Last bit: publish everything together so outputs appear as one registered set.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= cmp_q ? {{(WIDTH-1){1'b0}}, eq_next} : sum_next;
                        bus.cout      <= fa_cout;
                        bus.equal     <= eq_next;
                        bus.not_equal <= ~eq_next;
`ifdef SERIAL_ADDSUB_OVF_EN
                        bus.ovf       <= carry ^ fa_cout;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.result    <= '0;
                        bus.cout      <= 1'b0;
                        bus.equal     <= 1'b0;
                        bus.not_equal <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
                        bus.ovf       <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub6.sv
// Self-checking bench for serial_addsub6: directed cases from the plan plus random
// transactions, compared against an integer-arithmetic reference model.
module tb_serial_addsub6;
    import serial_addsub_pkg::*;

    localparam int W   = DEFAULT_WIDTH;
    localparam int MOD = 1 << W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_addsub6_if bus ();

    serial_addsub6 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full transaction: accept, wait out the serial run, hold under back-pressure, hand off.
    task automatic apply_stimulus(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                  input logic sub_v, input logic cmp_v, input int hold);
        int ai, bi, raw, sa, sb, sres, lat;
        logic [W-1:0] e_sum, e_res;
        logic e_cout, e_eq, e_ovf;

        ai = int'(a_v);
        bi = int'(b_v);
        raw    = sub_v ? (ai - bi + MOD) : (ai + bi);
        e_sum  = W'(raw % MOD);
        e_cout = sub_v ? (ai >= bi) : (raw >= MOD);
        e_eq   = (ai == bi);
        e_res  = cmp_v ? W'(e_eq) : e_sum;
        sa     = (ai >= MOD / 2) ? ai - MOD : ai;
        sb     = (bi >= MOD / 2) ? bi - MOD : bi;
        sres   = sub_v ? sa - sb : sa + sb;
        e_ovf  = (sres > MOD / 2 - 1) || (sres < -(MOD / 2));

        check_output("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.a        = a_v;
        bus.b        = b_v;
        bus.sub      = sub_v;
        bus.cmp      = cmp_v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.sub      = 1'($urandom);
        bus.cmp      = 1'($urandom);
        check_output("run_in_ready", 32'(bus.in_ready), 32'd0);

        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output("latency", 32'(lat), 32'(W));
        check_output("result", 32'(bus.result), 32'(e_res));
        check_output("cout", 32'(bus.cout), 32'(e_cout));
        check_output("equal", 32'(bus.equal), 32'(e_eq));
        check_output("not_equal", 32'(bus.not_equal), 32'(!e_eq));
`ifdef SERIAL_ADDSUB_OVF_EN
        check_output("ovf", 32'(bus.ovf), 32'(e_ovf));
`else
        if (e_ovf && e_eq && lat < 0) $display("[TB] unreachable");
`endif

        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_output("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check_output("hold_result", 32'(bus.result), 32'(e_res));
            check_output("hold_cout", 32'(bus.cout), 32'(e_cout));
            check_output("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_output("post_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("post_not_equal", 32'(bus.not_equal), 32'd0);
        check_output("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.cmp       = 1'b0;

        #12;
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_result", 32'(bus.result), 32'd0);
        check_output("rst_cout", 32'(bus.cout), 32'd0);
        check_output("rst_equal", 32'(bus.equal), 32'd0);
        check_output("rst_not_equal", 32'(bus.not_equal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed cases");
        apply_stimulus(6'b000001, 6'b000001, 1'b0, 1'b0, 0);
        apply_stimulus(6'b000001, 6'b000010, 1'b1, 1'b0, 1);
        apply_stimulus(6'b000001, 6'b000001, 1'b1, 1'b1, 0);
        apply_stimulus(6'd5, 6'd6, 1'b1, 1'b1, 0);
        apply_stimulus(6'b111111, 6'b000001, 1'b0, 1'b0, 5);
        apply_stimulus(6'b111111, 6'b000001, 1'b1, 1'b0, 0);
        apply_stimulus(6'b011111, 6'b000001, 1'b0, 1'b0, 0);
        apply_stimulus(6'b100000, 6'b000001, 1'b1, 1'b0, 0);

        $display("[TB] reset during RUN");
        bus.a        = 6'b101010;
        bus.b        = 6'b010101;
        bus.sub      = 1'b0;
        bus.cmp      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("abort_result", 32'(bus.result), 32'd0);
        check_output("abort_cout", 32'(bus.cout), 32'd0);
        check_output("abort_equal", 32'(bus.equal), 32'd0);
        check_output("abort_not_equal", 32'(bus.not_equal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(6'b000011, 6'b000101, 1'b0, 1'b0, 0);

        $display("[TB] random transactions");
        for (int t = 0; t < 24; t++) begin
            apply_stimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                           int'($urandom_range(0, 2)));
        end
        apply_stimulus(6'd17, 6'd17, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
